// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one synchronous-write memory between two masters.
// Each access takes IDLE -> ACCESS -> DONE; an optional per-port lock allows bounded bursts.
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dataW,
  input  logic [DATA_W-1:0] mem_dataR
);

  localparam int unsigned CntW = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                prio_q, prio_d;
  logic                lock_flag_q, lock_flag_d;
  logic                via_lock_q, via_lock_d;
  logic [CntW-1:0]     lock_cnt_q, lock_cnt_d;

  logic                winner;
  logic                own_req;
  logic                other_req;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    prio_d      = prio_q;
    lock_flag_d = lock_flag_q;
    via_lock_d  = via_lock_q;
    lock_cnt_d  = lock_cnt_q;
    winner      = 1'b0;
    own_req     = owner_q ? req1 : req0;
    other_req   = owner_q ? req0 : req1;

    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          // Previous owner keeps the memory only while the lock budget lasts or nobody waits.
          if (lock_flag_q && own_req &&
              ((lock_cnt_q < CntW'(MAX_LOCK)) || !other_req)) begin
            winner     = owner_q;
            via_lock_d = 1'b1;
            lock_cnt_d = (lock_cnt_q < CntW'(MAX_LOCK)) ? lock_cnt_q + CntW'(1) : lock_cnt_q;
          end else begin
            winner     = (req0 && req1) ? prio_q : req1;
            via_lock_d = 1'b0;
            lock_cnt_d = CntW'(1);
          end
          owner_d = winner;
          we_d    = winner ? we1 : we0;
          addr_d  = winner ? addr1 : addr0;
          wdata_d = winner ? wdata1 : wdata0;
          state_d = StAccess;
        end
      end
      StAccess: begin
        rdata_d = mem_dataR;
        state_d = StDone;
      end
      StDone: begin
        lock_flag_d = owner_q ? lock1 : lock0;
        if (!via_lock_q) prio_d = ~owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      prio_q      <= 1'b0;
      lock_flag_q <= 1'b0;
      via_lock_q  <= 1'b0;
      lock_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      prio_q      <= prio_d;
      lock_flag_q <= lock_flag_d;
      via_lock_q  <= via_lock_d;
      lock_cnt_q  <= lock_cnt_d;
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign mem_ce    = (state_q == StAccess);
  assign mem_we    = mem_ce & we_q;
  assign mem_addr  = addr_q;
  assign mem_dataW = wdata_q;
  assign rdata     = rdata_q;
  assign ack       = (state_q == StDone) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 256 x 16 memory.
module tb_mem_arbiter;

  logic        ck;
  logic        rst;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [7:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic [1:0]  ack;
  logic [15:0] rdata;
  logic        mem_ce, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_dataW;
  logic [15:0] mem_dataR;

  logic [15:0] mem [256];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [15:0] pl_data;

  int n_pass;
  int n_total;
  int ce_cnt;
  int we_cnt;
  int ce_snap;
  int we_snap;

  mem_arbiter #(
    .ADDR_W  (8),
    .DATA_W  (16),
    .MAX_LOCK(4)
  ) dut (
    .ck       (ck),
    .rst      (rst),
    .req0     (req0),
    .req1     (req1),
    .we0      (we0),
    .we1      (we1),
    .lock0    (lock0),
    .lock1    (lock1),
    .addr0    (addr0),
    .addr1    (addr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .ack      (ack),
    .rdata    (rdata),
    .mem_ce   (mem_ce),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_dataW(mem_dataW),
    .mem_dataR(mem_dataR)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  assign mem_dataR = mem[mem_addr];

  always @(posedge ck) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_we) mem[mem_addr] <= mem_dataW;
  end

  initial begin
    ce_cnt = 0;
    we_cnt = 0;
  end
  always @(negedge ck) begin
    if (mem_ce) ce_cnt = ce_cnt + 1;
    if (mem_we) we_cnt = we_cnt + 1;
  end

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_en   = 1'b0;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    pl_en   = 0;
    pl_addr = '0;
    pl_data = '0;
    idle_inputs();
    rst = 1'b1;
    #1;
    preload(8'd30, 16'h1111);
    preload(8'd31, 16'h2222);
    preload(8'd32, 16'h3333);
    preload(8'd5,  16'h0000);
    do_reset();

    // Reset values
    check("rst_ack",   32'(ack),       32'h0);
    check("rst_rdata", 32'(rdata),     32'h0);
    check("rst_ce",    32'(mem_ce),    32'h0);
    check("rst_we",    32'(mem_we),    32'h0);
    check("rst_addr",  32'(mem_addr),  32'h0);
    check("rst_dataW", 32'(mem_dataW), 32'h0);

    // Port 0 single read of addr 30
    ce_snap = ce_cnt;
    we_snap = we_cnt;
    req0 = 1; we0 = 0; addr0 = 8'd30;
    tick();
    check("rd0_ce",   32'(mem_ce),   32'h1);
    check("rd0_we",   32'(mem_we),   32'h0);
    check("rd0_addr", 32'(mem_addr), 32'd30);
    check("rd0_noack", 32'(ack),     32'h0);
    tick();
    check("rd0_ack",   32'(ack),    32'h1);
    check("rd0_rdata", 32'(rdata),  32'h1111);
    check("rd0_ce_off", 32'(mem_ce), 32'h0);
    req0 = 0;
    tick();
    check("rd0_ack_off", 32'(ack),      32'h0);
    check("rd0_addr_hold", 32'(mem_addr), 32'd30);
    check("rd0_ce_cycles", 32'(ce_cnt - ce_snap), 32'd1);
    check("rd0_we_cycles", 32'(we_cnt - we_snap), 32'd0);

    // Port 1 write 0xBEEF to 0x40 then read it back
    we_snap = we_cnt;
    req1 = 1; we1 = 1; addr1 = 8'h40; wdata1 = 16'hBEEF;
    tick();
    check("wr1_we",    32'(mem_we),    32'h1);
    check("wr1_dataW", 32'(mem_dataW), 32'hBEEF);
    tick();
    check("wr1_ack",   32'(ack),       32'h2);
    check("wr1_mem",   32'(mem[8'h40]), 32'hBEEF);
    we1 = 0;
    tick();
    check("rd1_idle_ack", 32'(ack), 32'h0);
    tick();
    check("rd1_ce", 32'(mem_ce), 32'h1);
    check("rd1_we", 32'(mem_we), 32'h0);
    tick();
    check("rd1_ack",   32'(ack),   32'h2);
    check("rd1_rdata", 32'(rdata), 32'hBEEF);
    req1 = 0;
    tick();
    check("wr1_we_cycles", 32'(we_cnt - we_snap), 32'd1);

    // Both ports reading continuously alternate
    do_reset();
    req0 = 1; addr0 = 8'd31;
    req1 = 1; addr1 = 8'd32;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_ce", 32'(mem_ce), 32'h1);
      tick();
      check("rr_ack",   32'(ack),   (k % 2 == 0) ? 32'h1 : 32'h2);
      check("rr_rdata", 32'(rdata), (k % 2 == 0) ? 32'h2222 : 32'h3333);
      if (k == 3) begin
        req0 = 0;
        req1 = 0;
      end
      tick();
    end

    // Port 0 locking against a waiting port 1: four port 0 grants, one port 1, then port 0
    do_reset();
    req0 = 1; lock0 = 1; addr0 = 8'd31;
    req1 = 1; addr1 = 8'd32;
    for (int k = 0; k < 6; k++) begin
      tick();
      tick();
      check("lk_ack",   32'(ack),   (k == 4) ? 32'h2 : 32'h1);
      check("lk_rdata", 32'(rdata), (k == 4) ? 32'h3333 : 32'h2222);
      if (k == 5) idle_inputs();
      tick();
    end

    // Port 0 locking with port 1 idle: back-to-back grants at the 3-cycle cadence
    do_reset();
    req0 = 1; lock0 = 1; addr0 = 8'd30;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("lk_solo_ce", 32'(mem_ce), 32'h1);
      tick();
      check("lk_solo_ack", 32'(ack), 32'h1);
      if (k == 9) idle_inputs();
      tick();
      check("lk_solo_gap", 32'(ack), 32'h0);
    end

    // Asynchronous reset in the ACCESS cycle of a port 1 write
    do_reset();
    req1 = 1; we1 = 1; addr1 = 8'd5; wdata1 = 16'hDEAD;
    tick();
    check("ar_we_before", 32'(mem_we), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_we",    32'(mem_we),    32'h0);
    check("ar_ce",    32'(mem_ce),    32'h0);
    check("ar_ack",   32'(ack),       32'h0);
    check("ar_addr",  32'(mem_addr),  32'h0);
    check("ar_dataW", 32'(mem_dataW), 32'h0);
    check("ar_rdata", 32'(rdata),     32'h0);
    idle_inputs();
    tick();
    check("ar_mem5", 32'(mem[8'd5]), 32'h0000);
    rst = 1'b0;
    tick();
    check("ar_ack_after", 32'(ack), 32'h0);
    req0 = 1; addr0 = 8'd31;
    req1 = 1; addr1 = 8'd32;
    tick();
    check("ar_next_addr", 32'(mem_addr), 32'd31);
    tick();
    check("ar_next_ack", 32'(ack), 32'h1);
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter sharing the single 256 x 16 program/data memory between the NanoCPU bus master (port 0) and a second master such as a loader or DMA engine (port 1). Each master issues one access at a time with a req/ack handshake. The arbiter latches the winning request, drives the memory's ce/we/address/dataW for exactly one cycle, then returns read data with a one-cycle ack. An optional per-port lock lets a master hold the memory for a bounded burst.

## Interface
- ADDR_W, 8: memory address width.
- DATA_W, 16: memory data width.
- MAX_LOCK, 4: maximum consecutive grants to a locking port while the other port is waiting (≥1).
- ck  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0, req1  in  1  access request; held until the matching ack.
- we0, we1  in  1  1 = write, 0 = read; sampled with req.
- lock0, lock1  in  1  request to keep the grant for the next access.
- addr0, addr1  in  ADDR_W  access address.
- wdata0, wdata1  in  DATA_W  write data.
- ack  out  2  one-cycle completion pulse, bit n for port n.
- rdata  out  DATA_W  read data; valid while ack is high (shared by both ports).
- mem_ce  out  1  memory enable.
- mem_we  out  1  memory write enable; the memory writes on the rising edge while it is high.
- mem_addr  out  ADDR_W  memory address.
- mem_dataW  out  DATA_W  memory write data.
- mem_dataR  in  DATA_W  memory read data, combinational from mem_addr.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If neither req is high, stay.
  - Otherwise pick the winner:
    - If the previous owner had its lock high at its DONE cycle, its req is high now, and lock_cnt < MAX_LOCK (or the other req is low), the previous owner wins.
    - Else round-robin: a port wins if it alone requests; if both request, the port named by prio_ptr wins.
  - Latch winner id, we, addr and wdata into internal registers; go to ACCESS.
- ACCESS:
  - mem_ce=1, mem_we=latched we, mem_addr and mem_dataW driven from the latched values.
  - Register mem_dataR into rdata on the rising edge that leaves ACCESS, for both reads and writes.
  - Go to DONE.
- DONE:
  - ack[winner]=1 and rdata held; go to IDLE.
  - prio_ptr := other port, unless the grant continues under lock.
- lock_cnt:
  - Increments on each consecutive grant to the same port via lock.
  - Resets to 1 on any round-robin grant.
  - Saturates at MAX_LOCK.
- Outside ACCESS: mem_ce=0, mem_we=0, mem_addr/mem_dataW hold their last values.
- Widths: addresses and data pass through unmodified; no arithmetic on the data path.

## Timing
- Reset values: state=IDLE, ack=0, rdata=0, mem_ce=0, mem_we=0, mem_addr=0, mem_dataW=0, prio_ptr=0 (port 0 first), lock_cnt=0, owner=port 0, lock flag cleared.
- Latency: req sampled high in IDLE at edge T; ACCESS during cycle T..T+1; ack high during cycle T+1..T+2.
  - Minimum 3 cycles per access; throughput is one access per 3 cycles.
- Requesters:
  - May change addr/we/wdata/req after the ack cycle only.
  - Inputs are ignored outside IDLE.
  - A req still high in the IDLE cycle after ack is treated as a new request.
- Both ports requesting continuously alternate strictly: 0,1,0,1… with no lock.
- A req dropped during ACCESS or DONE does not abort the access; ack is still issued.
- Write data lands in memory at the edge ending ACCESS, so a read of the same address by the other port is granted next and sees the new value.
- Lock with the other port idle: unlimited consecutive grants.
- Lock with the other port waiting: after MAX_LOCK consecutive grants the other port must win next.
- Asynchronous reset during ACCESS:
  - mem_we and mem_ce drop immediately; no write is performed.
  - No ack is issued; the FSM returns to IDLE.

## Test plan
- Reset, then hold port 0 read at addr 30 with memory[30]=0x1111: ack=2'b01 on the 3rd cycle after req, rdata=0x1111; mem_ce high exactly one cycle, mem_we never high.
- Port 1 writes 0xBEEF to addr 0x40, then reads addr 0x40: second ack carries rdata=0xBEEF; mem_we high for exactly one cycle.
- Both ports hold reads (addr 31 and addr 32) for 4 accesses: ack sequence 01,10,01,10; rdata alternates 0x2222/0x3333.
- Port 0 lock=1 with req held, port 1 req held, MAX_LOCK=4: four consecutive port 0 acks, then one port 1 ack, then port 0 again.
- Port 0 lock=1, port 1 idle: 10 consecutive port 0 acks, no gaps beyond the 3-cycle cadence.
- Assert rst in the ACCESS cycle of a port 1 write to addr 5 (old value 0x0000): no ack, memory[5] stays 0x0000, all outputs at reset values; next request is served with port 0 priority.
